hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 24 ++
 rtl/hazard_forward_unit_fwd_select.sv | 45 ++++
 rtl/hazard_forward_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit_pkg
// Purpose  : Shared definitions for the hazard / forwarding unit:
//            - forward-select encodings (FWD_NONE, FWD_MEM, FWD_WB)
//            - load-use stall FSM state type
// Revision : 1.0 - initial release
// ============================================================================
package hazard_forward_unit_pkg;

    // Operand source select for one EX-stage source mux.
    // 2'b11 is never produced.
    localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM  = 2'b01;  // EX/MEM result
    localparam logic [1:0] FWD_WB   = 2'b10;  // MEM/WB result

    // Load-use stall sequencer states.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage : hazard_forward_unit_pkg
`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : Priority forward select for one EX-stage source operand.
//            The MEM-stage producer wins over the WB-stage producer (it holds
//            the younger value). Loads in MEM cannot forward (data not yet
//            available), and register 0 is never forwarded.
// Ports    : i_src_reg         - EX-stage source register address
//            i_exmem_write_reg - MEM-stage destination
//            i_exmem_reg_write - MEM-stage write enable
//            i_exmem_mem_read  - MEM-stage instruction is a load
//            i_memwb_write_reg - WB-stage destination
//            i_memwb_reg_write - WB-stage write enable
//            o_fwd_sel         - FWD_NONE / FWD_MEM / FWD_WB
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src_reg,
    input  logic [REG_AW-1:0] i_exmem_write_reg,
    input  logic              i_exmem_reg_write,
    input  logic              i_exmem_mem_read,
    input  logic [REG_AW-1:0] i_memwb_write_reg,
    input  logic              i_memwb_reg_write,
    output logic [1:0]        o_fwd_sel
);
    import hazard_forward_unit_pkg::*;

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_exmem_reg_write && !i_exmem_mem_read &&
                       (i_exmem_write_reg != '0) &&
                       (i_exmem_write_reg == i_src_reg);

    assign w_wb_hit  = i_memwb_reg_write &&
                       (i_memwb_write_reg != '0) &&
                       (i_memwb_write_reg == i_src_reg);

    assign o_fwd_sel = w_mem_hit ? FWD_MEM :
                       w_wb_hit  ? FWD_WB  : FWD_NONE;

endmodule : fwd_select
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Purpose  : EX-stage operand forwarding plus load-use hazard stall control
//            for a 5-stage pipeline.
// Ports    : Clock          - single clock, rising edge
//            Reset          - synchronous, active-low
//            EX_SrcRegs     - EX source addresses, src i at [i*REG_AW +: REG_AW]
//            ID_SrcRegs     - ID source addresses, same packing
//            ID_SrcUsed     - per-source "actually read" flags
//            IDEX_MemRead   - instruction in EX is a load
//            IDEX_WriteReg  - destination of instruction in EX
//            EXMEM_*        - MEM-stage destination / write enable / load flag
//            MEMWB_*        - WB-stage destination / write enable
//            FWMuxControl   - forward select for src i at [2i +: 2]
//            Stall          - hold PC and IF/ID
//            Bubble         - zero the ID/EX control fields
//            StallCount     - saturating count of Stall cycles
//                             (only when HAZARD_STATS_EN is defined)
// Config   : `define HAZARD_STATS_EN to add the StallCount output.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1   // legal 1..4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_SRC*REG_AW-1:0] EX_SrcRegs,
    input  logic [NUM_SRC*REG_AW-1:0] ID_SrcRegs,
    input  logic [NUM_SRC-1:0]        ID_SrcUsed,
    input  logic                      IDEX_MemRead,
    input  logic [REG_AW-1:0]         IDEX_WriteReg,
    input  logic [REG_AW-1:0]         EXMEM_WriteReg,
    input  logic                      EXMEM_RegWrite,
    input  logic                      EXMEM_MemRead,
    input  logic [REG_AW-1:0]         MEMWB_WriteReg,
    input  logic                      MEMWB_RegWrite,
    output logic [2*NUM_SRC-1:0]      FWMuxControl,
    output logic                      Stall,
`ifdef HAZARD_STATS_EN
    output logic                      Bubble,
    output logic [31:0]               StallCount
`else
    output logic                      Bubble
`endif
);
    import hazard_forward_unit_pkg::*;

    // The hazard cycle itself is the first stall cycle, so the counter
    // covers the remaining LOAD_LAT-1 cycles and ends on zero.
    localparam logic [1:0] c_stall_init = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    logic [2*NUM_SRC-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]   w_id_hit;
    logic                 w_hazard;
    logic                 w_stall;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_stall_cnt;
    logic [1:0]           w_stall_cnt_nxt;

    // ------------------------------------------------------------------
    // Per-source forward selects and ID-stage hazard compares
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_select #(
                .REG_AW (REG_AW)
            ) u_fwd_select (
                .i_src_reg         (EX_SrcRegs[gi*REG_AW +: REG_AW]),
                .i_exmem_write_reg (EXMEM_WriteReg),
                .i_exmem_reg_write (EXMEM_RegWrite),
                .i_exmem_mem_read  (EXMEM_MemRead),
                .i_memwb_write_reg (MEMWB_WriteReg),
                .i_memwb_reg_write (MEMWB_RegWrite),
                .o_fwd_sel         (w_fwd_sel[2*gi +: 2])
            );

            assign w_id_hit[gi] = ID_SrcUsed[gi] &&
                                  (ID_SrcRegs[gi*REG_AW +: REG_AW] == IDEX_WriteReg);
        end
    endgenerate

    assign w_hazard = IDEX_MemRead && (IDEX_WriteReg != '0) && (|w_id_hit);

    // ------------------------------------------------------------------
    // Load-use stall sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= RUN;
            r_stall_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        w_stall         = 1'b0;
        case (r_state)
            RUN: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_state_nxt     = STALL;
                        w_stall_cnt_nxt = c_stall_init;
                    end
                end
            end
            STALL: begin
                // Hazard inputs are ignored here: the sequence always runs
                // to completion once started.
                w_stall = 1'b1;
                if (r_stall_cnt == 2'd0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt     = RUN;
                w_stall_cnt_nxt = 2'd0;
            end
        endcase
    end

    // All outputs are forced quiet while reset is held.
    assign Stall        = Reset & w_stall;
    assign Bubble       = Reset & w_stall;
    assign FWMuxControl = Reset ? w_fwd_sel : '0;

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    logic [31:0] r_stall_count;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_stall_count <= 32'd0;
        end else if (Stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign StallCount = r_stall_count;
`endif

endmodule : hazard_forward_unit
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_unit
// Purpose  : Self-checking bench for hazard_forward_unit. Two instances share
//            all inputs: one with LOAD_LAT=1, one with LOAD_LAT=3, both with
//            NUM_SRC=3. Expected values are hand-computed per cycle and
//            queued by the driver; a negedge monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 3;

    typedef struct packed {
        logic [5:0] fw;
        logic       s1;
        logic       s3;
    } exp_t;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] ex_src;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_used;
    logic                      idex_mr;
    logic [REG_AW-1:0]         idex_wr;
    logic [REG_AW-1:0]         exmem_wr;
    logic                      exmem_rw;
    logic                      exmem_mr;
    logic [REG_AW-1:0]         memwb_wr;
    logic                      memwb_rw;

    logic [5:0] fw1, fw3;
    logic       stall1, bub1, stall3, bub3;
`ifdef HAZARD_STATS_EN
    logic [31:0] cnt1, cnt3;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    string name_q[$];
    exp_t  mon_e;
    string mon_nm;

    hazard_forward_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LOAD_LAT(1)) u_dut_l1 (
        .Clock          (clk),
        .Reset          (rst_n),
        .EX_SrcRegs     (ex_src),
        .ID_SrcRegs     (id_src),
        .ID_SrcUsed     (id_used),
        .IDEX_MemRead   (idex_mr),
        .IDEX_WriteReg  (idex_wr),
        .EXMEM_WriteReg (exmem_wr),
        .EXMEM_RegWrite (exmem_rw),
        .EXMEM_MemRead  (exmem_mr),
        .MEMWB_WriteReg (memwb_wr),
        .MEMWB_RegWrite (memwb_rw),
        .FWMuxControl   (fw1),
        .Stall          (stall1),
`ifdef HAZARD_STATS_EN
        .Bubble         (bub1),
        .StallCount     (cnt1)
`else
        .Bubble         (bub1)
`endif
    );

    hazard_forward_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .LOAD_LAT(3)) u_dut_l3 (
        .Clock          (clk),
        .Reset          (rst_n),
        .EX_SrcRegs     (ex_src),
        .ID_SrcRegs     (id_src),
        .ID_SrcUsed     (id_used),
        .IDEX_MemRead   (idex_mr),
        .IDEX_WriteReg  (idex_wr),
        .EXMEM_WriteReg (exmem_wr),
        .EXMEM_RegWrite (exmem_rw),
        .EXMEM_MemRead  (exmem_mr),
        .MEMWB_WriteReg (memwb_wr),
        .MEMWB_RegWrite (memwb_rw),
        .FWMuxControl   (fw3),
        .Stall          (stall3),
`ifdef HAZARD_STATS_EN
        .Bubble         (bub3),
        .StallCount     (cnt3)
`else
        .Bubble         (bub3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string what,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s: actual %0h required %0h", nm, what, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            chk(mon_nm, "fw_l1",     32'(fw1),    32'(mon_e.fw));
            chk(mon_nm, "fw_l3",     32'(fw3),    32'(mon_e.fw));
            chk(mon_nm, "stall_l1",  32'(stall1), 32'(mon_e.s1));
            chk(mon_nm, "bubble_l1", 32'(bub1),   32'(mon_e.s1));
            chk(mon_nm, "stall_l3",  32'(stall3), 32'(mon_e.s3));
            chk(mon_nm, "bubble_l3", 32'(bub3),   32'(mon_e.s3));
        end
    end

    task automatic set_fwd(input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] s0,
                           input logic [4:0] exw, input logic exrw, input logic exmr,
                           input logic [4:0] mww, input logic mwrw);
        ex_src   = {s2, s1, s0};
        exmem_wr = exw;
        exmem_rw = exrw;
        exmem_mr = exmr;
        memwb_wr = mww;
        memwb_rw = mwrw;
    endtask

    task automatic set_haz(input logic mr, input logic [4:0] wr,
                           input logic [4:0] i2, input logic [4:0] i1, input logic [4:0] i0,
                           input logic [2:0] used);
        idex_mr = mr;
        idex_wr = wr;
        id_src  = {i2, i1, i0};
        id_used = used;
    endtask

    // Queue the expectation for the current cycle, then advance one cycle.
    task automatic cyc(input string nm, input logic [5:0] fw, input logic s1, input logic s3);
        exp_t e;
        e.fw = fw;
        e.s1 = s1;
        e.s3 = s3;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] F = 6'b000001;

    initial begin
        rst_n = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        set_haz(0, 0, 0, 0, 0, 3'b000);
        @(posedge clk);
        #1;

        // Reset held with active forwarding and hazard inputs: all quiet
        set_fwd(0, 0, 8, 8, 1, 0, 8, 1);
        set_haz(1, 9, 0, 9, 0, 3'b010);
        cyc("reset_gate", 6'b000000, 0, 0);
        rst_n = 1'b1;

        // Forwarding
        set_haz(0, 0, 0, 0, 0, 3'b000);
        set_fwd(0, 0, 8, 8, 1, 0, 8, 1);  cyc("mem_priority", 6'b000001, 0, 0);
        set_fwd(0, 0, 8, 8, 1, 1, 8, 1);  cyc("load_not_fwd", 6'b000010, 0, 0);
        set_fwd(0, 0, 0, 0, 1, 0, 0, 1);  cyc("reg0_never",   6'b000000, 0, 0);
        set_fwd(0, 0, 8, 8, 0, 0, 8, 0);  cyc("wen_low",      6'b000000, 0, 0);
        set_fwd(6, 5, 4, 4, 1, 0, 5, 1);  cyc("three_src",    6'b001001, 0, 0);
        set_fwd(5, 5, 4, 5, 1, 0, 5, 1);  cyc("mem_over_wb",  6'b010100, 0, 0);

        // Non-hazards
        set_fwd(0, 0, 0, 0, 0, 0, 0, 0);
        set_haz(1, 9, 0, 9, 0, 3'b101);   cyc("unused_src",   6'b000000, 0, 0);
        set_haz(0, 9, 0, 9, 0, 3'b010);   cyc("no_load",      6'b000000, 0, 0);
        set_haz(1, 0, 0, 0, 0, 3'b111);   cyc("load_to_r0",   6'b000000, 0, 0);

        // Single hazard; forwarding stays live during the stall
        set_fwd(0, 0, 4, 4, 1, 0, 0, 0);
        set_haz(1, 9, 0, 9, 0, 3'b010);   cyc("haz_a",        F, 1, 1);
        set_haz(0, 0, 0, 0, 0, 3'b000);   cyc("haz_b",        F, 0, 1);
        set_haz(1, 7, 0, 0, 7, 3'b001);   cyc("haz_c_ignored", F, 1, 1);
        set_haz(0, 0, 0, 0, 0, 3'b000);   cyc("haz_done",     F, 0, 0);

        // Hazard held: restarts in the first RUN cycle after STALL
        set_haz(1, 9, 9, 0, 0, 3'b100);
        cyc("held_e", F, 1, 1);
        cyc("held_f", F, 1, 1);
        cyc("held_g", F, 1, 1);
        cyc("held_h", F, 1, 1);
        set_haz(0, 0, 0, 0, 0, 3'b000);
        cyc("held_i", F, 0, 1);
        cyc("held_j", F, 0, 1);
        cyc("held_k", F, 0, 0);

        // Reset in the second stall cycle aborts the sequence
        set_haz(1, 9, 0, 9, 0, 3'b010);   cyc("rst_l",        F, 1, 1);
        set_haz(0, 0, 0, 0, 0, 3'b000);
        rst_n = 1'b0;                     cyc("rst_m",        6'b000000, 0, 0);
        rst_n = 1'b1;                     cyc("rst_n",        F, 0, 0);
        set_haz(1, 9, 0, 9, 0, 3'b010);   cyc("post_o",       F, 1, 1);
        set_haz(0, 0, 0, 0, 0, 3'b000);
        cyc("post_p", F, 0, 1);
        cyc("post_q", F, 0, 1);
        cyc("post_r", F, 0, 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual %0d pending required 0", exp_q.size());
        end

`ifdef HAZARD_STATS_EN
        // Counters were cleared at rst_m; one hazard afterwards.
        chk("stats", "count_l3", cnt3, 32'd3);
        chk("stats", "count_l1", cnt1, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_forward_unit
`default_nettype wire
